// File: rtl/wb_sram_arb_pkg.sv
// Shared types and helpers for the multi-master Wishbone-to-SRAM arbiter.
package wb_sram_arb_pkg;

  // Access sequencer states: one SRAM cycle per beat, then ACK, then a
  // one-cycle look at the owner's request to decide on burst continuation.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int WB_ADR_WIDTH   = 32;
  localparam int MAX_MASTERS    = 4;
  localparam int BEAT_CNT_WIDTH = 4;

  // Number of byte-offset bits dropped from a Wishbone byte address.
  function automatic int byte_shift(input int data_width);
    return (data_width == 64) ? 3 : 2;
  endfunction

  // Round-robin pick: first requester at or above ptr, wrapping at n.
  function automatic logic [1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                         input logic [1:0] ptr,
                                         input int n);
    logic [1:0] win;
    logic       found;
    int         idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req[idx[1:0]]) begin
        win   = idx[1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_sram_rr_arbiter.sv
// Round-robin winner select with a registered priority pointer.
module wb_sram_rr_arbiter
  import wb_sram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  input  logic [GW-1:0] i_gnt,
  output logic [GW-1:0] o_winner
);

  logic [GW-1:0] r_ptr;

  assign o_winner = GW'(rr_pick(MAX_MASTERS'(i_req), 2'(r_ptr), N));

  // Move priority to the master after the one just released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (i_gnt == GW'(N - 1)) ? '0 : i_gnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Shares one byte-enable SRAM between several Wishbone masters with
// round-robin arbitration and a bounded number of beats per grant.
module wb_sram_arbiter
  import wb_sram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int N_MASTERS     = 2,
  parameter int MAX_BURST     = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_MASTERS-1:0]                     i_wb_cyc,
  input  logic [N_MASTERS-1:0]                     i_wb_stb,
  input  logic [N_MASTERS-1:0]                     i_wb_we,
  input  logic [N_MASTERS-1:0][WB_ADR_WIDTH-1:0]   i_wb_adr,
  input  logic [N_MASTERS-1:0][DATA_WIDTH/8-1:0]   i_wb_sel,
  input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]     i_wb_dat_w,
  output logic [N_MASTERS-1:0]                     o_wb_ack,
  output logic [N_MASTERS-1:0][DATA_WIDTH-1:0]     o_wb_dat_r,
  output logic [N_MASTERS-1:0]                     o_wb_err,
  output logic [N_MASTERS-1:0]                     o_wb_tgd_r,
  output logic [ADDRESS_WIDTH-1:0]                 o_sram_addr,
  output logic                                     o_sram_read_en,
  output logic                                     o_sram_write_en,
  output logic [DATA_WIDTH/8-1:0]                  o_sram_byte_en,
  output logic [DATA_WIDTH-1:0]                    o_sram_write_data,
  input  logic [DATA_WIDTH-1:0]                    i_sram_read_data
);

  localparam int B  = byte_shift(DATA_WIDTH);
  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = BEAT_CNT_WIDTH;

  state_t                    r_state;
  logic [GW-1:0]             r_gnt;
  logic [CW-1:0]             r_beat_cnt;
  logic [N_MASTERS-1:0]      r_ack;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic                      r_read_en;
  logic                      r_write_en;
  logic [DATA_WIDTH/8-1:0]   r_byte_en;
  logic [DATA_WIDTH-1:0]     r_write_data;

  logic [N_MASTERS-1:0]      w_req;
  logic [GW-1:0]             w_winner;
  logic [GW-1:0]             w_cap_idx;
  logic [WB_ADR_WIDTH-1:0]   w_cap_adr;
  logic                      w_gnt_cyc;
  logic                      w_gnt_req;
  logic                      w_continue;
  logic                      w_resp_drop;
  logic                      w_take;
  logic                      w_advance;
  logic                      w_unused_adr;

  // A request needs both CYC and STB; CYC alone holds nothing.
  assign w_req       = i_wb_cyc & i_wb_stb;
  assign w_gnt_cyc   = i_wb_cyc[r_gnt];
  assign w_gnt_req   = w_req[r_gnt];
  assign w_continue  = w_gnt_req && (r_beat_cnt < CW'(MAX_BURST - 1));
  // No ACK pending means the owner already left during ACCESS.
  assign w_resp_drop = !(|r_ack) || !w_gnt_cyc;
  assign w_take      = ((r_state == IDLE) && (|w_req)) || ((r_state == HOLD) && w_continue);
  assign w_advance   = ((r_state == RESP) && w_resp_drop) || ((r_state == HOLD) && !w_continue);
  // New grants capture from the winner, burst beats from the current owner.
  assign w_cap_idx   = (r_state == IDLE) ? w_winner : r_gnt;
  assign w_cap_adr   = i_wb_adr[w_cap_idx];
  assign w_unused_adr = ^{w_cap_adr[WB_ADR_WIDTH-1:ADDRESS_WIDTH+B], w_cap_adr[B-1:0]};

  wb_sram_rr_arbiter #(
    .N  (N_MASTERS),
    .GW (GW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_advance (w_advance),
    .i_gnt     (r_gnt),
    .o_winner  (w_winner)
  );

  // Access sequencer: capture, one SRAM cycle, one ACK, then burst decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_beat_cnt   <= '0;
      r_ack        <= '0;
      r_addr       <= '0;
      r_read_en    <= 1'b0;
      r_write_en   <= 1'b0;
      r_byte_en    <= '0;
      r_write_data <= '0;
    end else begin
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_ack      <= '0;
      if (w_take) begin
        r_addr       <= w_cap_adr[ADDRESS_WIDTH-1+B:B];
        r_byte_en    <= i_wb_sel[w_cap_idx];
        r_write_data <= i_wb_dat_w[w_cap_idx];
        r_read_en    <= !i_wb_we[w_cap_idx];
        r_write_en   <= i_wb_we[w_cap_idx];
      end
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_gnt      <= w_winner;
            r_beat_cnt <= '0;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_gnt_cyc) begin
            r_ack[r_gnt] <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_state <= w_resp_drop ? IDLE : HOLD;
        end
        HOLD: begin
          if (w_continue) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_state    <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sram_addr       = r_addr;
  assign o_sram_read_en    = r_read_en;
  assign o_sram_write_en   = r_write_en;
  assign o_sram_byte_en    = r_byte_en;
  assign o_sram_write_data = r_write_data;

  // Per-port responses: ACK only to a master still holding CYC, data only to the owner.
  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_port
      assign o_wb_ack[gi]   = r_ack[gi] & i_wb_cyc[gi];
      assign o_wb_dat_r[gi] = (r_gnt == GW'(gi)) ? i_sram_read_data : '0;
      assign o_wb_err[gi]   = 1'b0;
      assign o_wb_tgd_r[gi] = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed bench for wb_sram_arbiter with a behavioural byte-enable SRAM.
module tb_wb_sram_arbiter;
  import wb_sram_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NM = 2;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]        cyc = '0;
  logic [NM-1:0]        stb = '0;
  logic [NM-1:0]        we  = '0;
  logic [NM-1:0][31:0]  adr = '0;
  logic [NM-1:0][3:0]   sel = '0;
  logic [NM-1:0][31:0]  dat_w = '0;
  logic [NM-1:0]        ack;
  logic [NM-1:0][31:0]  dat_r;
  logic [NM-1:0]        err;
  logic [NM-1:0]        tgd;
  logic [AW-1:0]        s_addr;
  logic                 s_re;
  logic                 s_we;
  logic [3:0]           s_be;
  logic [31:0]          s_wd;
  logic [31:0]          s_rd;

  logic [31:0] mem [0:1023];
  int          wr_count;
  int          errors = 0;
  int          checks = 0;

  wb_sram_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .N_MASTERS     (NM),
    .MAX_BURST     (MB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_wb_cyc          (cyc),
    .i_wb_stb          (stb),
    .i_wb_we           (we),
    .i_wb_adr          (adr),
    .i_wb_sel          (sel),
    .i_wb_dat_w        (dat_w),
    .o_wb_ack          (ack),
    .o_wb_dat_r        (dat_r),
    .o_wb_err          (err),
    .o_wb_tgd_r        (tgd),
    .o_sram_addr       (s_addr),
    .o_sram_read_en    (s_re),
    .o_sram_write_en   (s_we),
    .o_sram_byte_en    (s_be),
    .o_sram_write_data (s_wd),
    .i_sram_read_data  (s_rd)
  );

  // SRAM model: preset contents while in reset, one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      mem[4]   <= 32'h11223344;
      mem[8]   <= 32'hDEADBEEF;
      mem[9]   <= 32'h0BADF00D;
      mem[12]  <= 32'h00000000;
      for (int j = 0; j < 6; j++) mem[16+j] <= 32'h5A000000 + 32'(j);
      wr_count <= 0;
    end else begin
      if (s_we) begin
        for (int b = 0; b < 4; b++) if (s_be[b]) mem[s_addr][8*b +: 8] <= s_wd[8*b +: 8];
        wr_count <= wr_count + 1;
      end
      if (s_re) s_rd <= mem[s_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w;
    adr[m] = a; sel[m] = s; dat_w[m] = d;
  endtask

  task automatic clr_req(input int m);
    cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0;
  endtask

  // Single transfer from an idle arbiter; lat is negedges until ACK, -1 on timeout.
  task automatic wb_xfer(input int m, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rdata, output int lat);
    lat = -1; rdata = '0;
    set_req(m, w, a, s, d);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack[m]) begin lat = k; rdata = dat_r[m]; break; end
      tick();
    end
    tick();
    clr_req(m);
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    @(negedge clk);
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", ack); end
    checks++; if (s_re !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b want 0", s_re); end
    checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b want 0", s_we); end
    checks++; if (s_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", s_addr); end
    checks++; if (s_be !== 4'd0) begin errors++; $display("FAIL reset_byte_en: got %b want 0000", s_be); end
    checks++; if (s_wd !== 32'd0) begin errors++; $display("FAIL reset_write_data: got %h want 0", s_wd); end
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.r_state); end
    checks++; if (dut.u_arb.r_ptr !== 1'b0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut.u_arb.r_ptr); end
    checks++; if (dut.r_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %0d want 0", dut.r_gnt); end
    checks++; if (dut.r_beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_beat_cnt: got %0d want 0", dut.r_beat_cnt); end
    checks++; if ({err, tgd} !== 4'b0000) begin errors++; $display("FAIL reset_err_tgd: got %b want 0000", {err, tgd}); end
    tick();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int          lat;
    int          wc0;
    wc0 = wr_count;
    set_req(0, 1'b1, 32'h10, 4'b0011, 32'hAABBCCDD);
    @(negedge clk);
    checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL wr_idle_we: got %b want 0", s_we); end
    tick(); @(negedge clk);
    checks++; if (s_we !== 1'b1 || s_re !== 1'b0) begin errors++; $display("FAIL wr_access_en: got we=%b re=%b want we=1 re=0", s_we, s_re); end
    checks++; if (s_addr !== 10'd4) begin errors++; $display("FAIL wr_addr: got %h want 004", s_addr); end
    checks++; if (s_be !== 4'b0011) begin errors++; $display("FAIL wr_byte_en: got %b want 0011", s_be); end
    checks++; if (s_wd !== 32'hAABBCCDD) begin errors++; $display("FAIL wr_data: got %h want aabbccdd", s_wd); end
    tick(); @(negedge clk);
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL wr_ack: got %b want 01", ack); end
    checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL wr_resp_we: got %b want 0", s_we); end
    checks++; if (dat_r[1] !== 32'd0) begin errors++; $display("FAIL wr_other_dat_r: got %h want 0", dat_r[1]); end
    tick(); clr_req(0); @(negedge clk);
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL wr_hold_ack: got %b want 00", ack); end
    tick();
    checks++; if (wr_count - wc0 !== 1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_count - wc0); end
    checks++; if (mem[4] !== 32'h1122CCDD) begin errors++; $display("FAIL wr_mem: got %h want 1122ccdd", mem[4]); end
    $display("write m0 adr=10 sel=0011 -> mem[4]=%h", mem[4]);
    wb_xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++; if (rd[15:0] !== 16'hCCDD) begin errors++; $display("FAIL rd_low: got %h want ccdd", rd[15:0]); end
    checks++; if (rd !== 32'h1122CCDD) begin errors++; $display("FAIL rd_data: got %h want 1122ccdd", rd); end
    $display("read m0 adr=10 -> %h lat=%0d", rd, lat);
  endtask

  task automatic test_simultaneous();
    int          m0k, m1k, overlap, ptr_mid;
    logic [31:0] d0, d1;
    logic [1:0]  a;
    rst = 1'b1; tick(); rst = 1'b0;
    m0k = -1; m1k = -1; overlap = 0; ptr_mid = -1; d0 = '0; d1 = '0;
    set_req(0, 1'b0, 32'h20, 4'hF, 32'h0);
    set_req(1, 1'b0, 32'h24, 4'hF, 32'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a = ack;
      if (a == 2'b11) overlap++;
      if (k == 5) ptr_mid = int'(dut.u_arb.r_ptr);
      if (a[0] && m0k < 0) begin m0k = k; d0 = dat_r[0]; end
      if (a[1] && m1k < 0) begin m1k = k; d1 = dat_r[1]; end
      tick();
      if (a[0]) clr_req(0);
      if (a[1]) clr_req(1);
    end
    checks++; if (m0k !== 2) begin errors++; $display("FAIL sim_m0_ack_cycle: got %0d want 2", m0k); end
    checks++; if (m1k !== 6) begin errors++; $display("FAIL sim_m1_ack_cycle: got %0d want 6", m1k); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL sim_overlap: got %0d want 0", overlap); end
    checks++; if (d0 !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_m0_data: got %h want deadbeef", d0); end
    checks++; if (d1 !== 32'h0BADF00D) begin errors++; $display("FAIL sim_m1_data: got %h want 0badf00d", d1); end
    checks++; if (ptr_mid !== 1) begin errors++; $display("FAIL sim_ptr_mid: got %0d want 1", ptr_mid); end
    checks++; if (dut.u_arb.r_ptr !== 1'b0) begin errors++; $display("FAIL sim_ptr_end: got %0d want 0", dut.u_arb.r_ptr); end
    $display("simultaneous: m0 ack@%0d m1 ack@%0d", m0k, m1k);
  endtask

  task automatic test_burst_limit();
    int          exp_k[6] = '{2, 5, 8, 11, 19, 22};
    int          m1k[6];
    logic [31:0] m1d[6];
    logic [31:0] e;
    int          beats, m0k, overlap;
    logic [1:0]  a;
    for (int j = 0; j < 6; j++) begin m1k[j] = -1; m1d[j] = '0; end
    beats = 0; m0k = -1; overlap = 0;
    set_req(1, 1'b0, 32'h40, 4'hF, 32'h0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      a = ack;
      if (a == 2'b11) overlap++;
      if (a[1] && beats < 6) begin m1k[beats] = k; m1d[beats] = dat_r[1]; beats++; end
      if (a[0] && m0k < 0) m0k = k;
      tick();
      if (k == 0) set_req(0, 1'b0, 32'h20, 4'hF, 32'h0);
      if (a[1]) begin
        if (beats >= 6) clr_req(1);
        else adr[1] = 32'h40 + 32'(4 * beats);
      end
      if (a[0]) clr_req(0);
    end
    for (int j = 0; j < 6; j++) begin
      e = 32'h5A000000 + 32'(j);
      checks++; if (m1k[j] !== exp_k[j]) begin errors++; $display("FAIL burst_m1_ack_cycle[%0d]: got %0d want %0d", j, m1k[j], exp_k[j]); end
      checks++; if (m1d[j] !== e) begin errors++; $display("FAIL burst_m1_data[%0d]: got %h want %h", j, m1d[j], e); end
      $display("burst m1 beat %0d ack@%0d data=%h", j, m1k[j], m1d[j]);
    end
    checks++; if (m0k !== 15) begin errors++; $display("FAIL burst_m0_ack_cycle: got %0d want 15", m0k); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL burst_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_abandon();
    int wc0, acks;
    wc0 = wr_count; acks = 0;
    set_req(0, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
    @(negedge clk); if (ack != 2'b00) acks++;
    tick(); @(negedge clk);
    checks++; if (s_we !== 1'b1) begin errors++; $display("FAIL abandon_access_we: got %b want 1", s_we); end
    clr_req(0);
    tick(); @(negedge clk);
    if (ack != 2'b00) acks++;
    checks++; if (dut.r_ack !== 2'b00) begin errors++; $display("FAIL abandon_ack_reg: got %b want 00", dut.r_ack); end
    tick(); @(negedge clk);
    if (ack != 2'b00) acks++;
    checks++; if (acks !== 0) begin errors++; $display("FAIL abandon_ack: got %0d acks want 0", acks); end
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL abandon_state: got %0d want IDLE", dut.r_state); end
    checks++; if (mem[12] !== 32'hCAFEF00D) begin errors++; $display("FAIL abandon_mem: got %h want cafef00d", mem[12]); end
    checks++; if (wr_count - wc0 !== 1) begin errors++; $display("FAIL abandon_wr_count: got %0d want 1", wr_count - wc0); end
    checks++; if (dut.u_arb.r_ptr !== 1'b1) begin errors++; $display("FAIL abandon_ptr: got %0d want 1", dut.u_arb.r_ptr); end
    $display("abandon: mem[12]=%h acks=%0d", mem[12], acks);
    tick();
  endtask

  task automatic test_mid_reset();
    int         fk;
    logic [1:0] first;
    logic       m1_done;
    set_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clk); tick(); @(negedge clk); tick(); @(negedge clk);
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL mrst_pre_ack: got %b want 01", ack); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL mrst_ack: got %b want 00", ack); end
    checks++; if ({s_re, s_we} !== 2'b00) begin errors++; $display("FAIL mrst_en: got %b want 00", {s_re, s_we}); end
    checks++; if (s_addr !== 10'd0) begin errors++; $display("FAIL mrst_addr: got %h want 0", s_addr); end
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL mrst_state: got %0d want IDLE", dut.r_state); end
    checks++; if (dut.u_arb.r_ptr !== 1'b0) begin errors++; $display("FAIL mrst_ptr: got %0d want 0", dut.u_arb.r_ptr); end
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 32'h20, 4'hF, 32'h0);
    set_req(1, 1'b0, 32'h24, 4'hF, 32'h0);
    fk = -1; first = '0; m1_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack != 2'b00) begin first = ack; fk = k; break; end
      tick();
    end
    checks++; if (first !== 2'b01) begin errors++; $display("FAIL mrst_first_grant: got %b want 01", first); end
    checks++; if (fk !== 2) begin errors++; $display("FAIL mrst_latency: got %0d want 2", fk); end
    tick(); clr_req(0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack[1]) begin m1_done = 1'b1; break; end
      tick();
    end
    checks++; if (m1_done !== 1'b1) begin errors++; $display("FAIL mrst_m1_served: got %b want 1", m1_done); end
    tick(); clr_req(1); tick(); tick();
    $display("mid_reset: first grant %b after %0d cycles", first, fk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_burst_limit();
    test_abandon();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
